// File: rtl/prog_loader_pkg.sv
// Shared types and stream-format constants for the program loader.
// PROG_LOADER_CHECKSUM_EN adds the trailing checksum states.
package prog_loader_pkg;

    localparam int LEN_BYTES = 2;
    localparam int LEN_W     = 8 * LEN_BYTES;
    localparam int WORD_W    = 16;
    localparam int CSUM_W    = 16;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM_HI,
        CSUM_LO,
`endif
        DONE,
        ERROR
    } state_t;

    function automatic logic is_loading(input state_t s);
        case (s)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO: return 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM_HI, CSUM_LO:                 return 1'b1;
`endif
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host-side bundle for the program loader: byte stream in, imem writes
// and status out. master = stream host, slave = loader.
interface prog_loader_if #(
    parameter int ADDR_W = 16
) ();
    import prog_loader_pkg::*;

    logic              start;
    logic [7:0]        bdata;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, bdata, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_data,
        input  cpu_hold, done, error
    );

    modport slave (
        input  start, bdata, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_data,
        output cpu_hold, done, error
    );

endinterface

// File: rtl/prog_loader.sv
// Streams a length-prefixed image of 16-bit words into instruction memory
// while holding the CPU. PROG_LOADER_CHECKSUM_EN enables the trailing sum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [WORD_W-1:0] o_imem_data,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [32:0]       LIMIT = 33'd1 << ADDR_W;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t LAST = CSUM_HI;
`else
    localparam state_t LAST = DONE;
`endif

    state_t            state_q, state_d;
    logic              ready_q, we_q, we_d;
    logic              hold_q, done_q, error_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] csum_q, csum_d;
`endif
    logic              fire;
    logic [15:0]       word;
    logic [32:0]       end_addr;

    assign fire     = i_byte_valid & ready_q;
    assign word     = {hi_q, i_byte};
    assign end_addr = 33'(BASE_ADDR) + 33'(word);

    always_comb begin
        state_d = state_q;
        addr_d  = we_q ? addr_q + 1'b1 : addr_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (i_start) begin
            state_d = LEN_HI;
            addr_d  = BASE;
            cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
        end else if (fire) begin
            case (state_q)
                LEN_HI: begin
                    hi_d    = i_byte;
                    state_d = LEN_LO;
                end
                LEN_LO: begin
                    len_d = word;
                    // Reject images that would run past the top of imem
                    if (end_addr > LIMIT)  state_d = ERROR;
                    else if (word == '0)   state_d = LAST;
                    else                   state_d = DATA_HI;
                end
                DATA_HI: begin
                    hi_d    = i_byte;
                    state_d = DATA_LO;
                end
                DATA_LO: begin
                    we_d    = 1'b1;
                    data_d  = word;
                    cnt_d   = cnt_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q + word;
`endif
                    state_d = (cnt_q + 1'b1 == len_q) ? LAST : DATA_HI;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM_HI: begin
                    hi_d    = i_byte;
                    state_d = CSUM_LO;
                end
                CSUM_LO: begin
                    state_d = (word == csum_q) ? DONE : ERROR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= is_loading(state_d);
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            hold_q  <= !(state_d == IDLE || state_d == DONE);
            done_q  <= (state_d == DONE);
            error_q <= (state_d == ERROR);
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign o_byte_ready = ready_q;
    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_data  = data_q;
    assign o_cpu_hold   = hold_q;
    assign o_done       = done_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader (default and ADDR_W=4 instances).
// Honours PROG_LOADER_CHECKSUM_EN by appending checksums to streams.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(16)) bus ();
    prog_loader_if #(.ADDR_W(4))  bus4 ();

    prog_loader #(.ADDR_W(16), .BASE_ADDR(0)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (bus.start),
        .i_byte       (bus.bdata),
        .i_byte_valid (bus.byte_valid),
        .o_byte_ready (bus.byte_ready),
        .o_imem_we    (bus.imem_we),
        .o_imem_addr  (bus.imem_addr),
        .o_imem_data  (bus.imem_data),
        .o_cpu_hold   (bus.cpu_hold),
        .o_done       (bus.done),
        .o_error      (bus.error)
    );

    prog_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_start      (bus4.start),
        .i_byte       (bus4.bdata),
        .i_byte_valid (bus4.byte_valid),
        .o_byte_ready (bus4.byte_ready),
        .o_imem_we    (bus4.imem_we),
        .o_imem_addr  (bus4.imem_addr),
        .o_imem_data  (bus4.imem_data),
        .o_cpu_hold   (bus4.cpu_hold),
        .o_done       (bus4.done),
        .o_error      (bus4.error)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   wr4   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         bus.imem_addr, bus.imem_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("wr_data", 32'(bus.imem_data), 32'(e.data));
            end
        end
        if (bus4.imem_we === 1'b1) wr4++;
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        bus.bdata      = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %0h ready %b expected 1",
                     b, bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gap);
        foreach (s[i]) send(s[i], gap);
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: done %b error %b expected one set",
                     name, bus.done, bus.error);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic push_two();
        exp_q.push_back('{16'h0000, 16'h1234});
        exp_q.push_back('{16'h0001, 16'hABCD});
    endtask

    logic [7:0] two_words[$];
    logic [7:0] empty_img[$];
    logic [7:0] partial[$];

    initial begin
        bus.start = 1'b0;
        bus.bdata = 8'h00;
        bus.byte_valid = 1'b0;
        bus4.start = 1'b0;
        bus4.bdata = 8'h00;
        bus4.byte_valid = 1'b0;

        two_words = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        empty_img = '{8'h00, 8'h00};
        partial   = '{8'h00, 8'h02, 8'h12};
`ifdef PROG_LOADER_CHECKSUM_EN
        two_words.push_back(8'hBE);
        two_words.push_back(8'h01);
        empty_img.push_back(8'h00);
        empty_img.push_back(8'h00);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_we",    32'(bus.imem_we),    32'd0);
        check("rst_addr",  32'(bus.imem_addr),  32'd0);
        check("rst_data",  32'(bus.imem_data),  32'd0);
        check("rst_hold",  32'(bus.cpu_hold),   32'd0);
        check("rst_done",  32'(bus.done),       32'd0);
        check("rst_error", 32'(bus.error),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word load, valid held high
        pulse_start();
        check("start_ready", 32'(bus.byte_ready), 32'd1);
        check("start_hold",  32'(bus.cpu_hold),   32'd1);
        push_two();
        send_stream(two_words, 1'b0);
        wait_end("load1");
        check("load1_done",  32'(bus.done),       32'd1);
        check("load1_error", 32'(bus.error),      32'd0);
        check("load1_hold",  32'(bus.cpu_hold),   32'd0);
        check("load1_ready", 32'(bus.byte_ready), 32'd0);
        check("load1_left",  32'(exp_q.size()),   32'd0);

        // Same load, valid toggled every other cycle
        pulse_start();
        check("restart_done", 32'(bus.done), 32'd0);
        push_two();
        send_stream(two_words, 1'b1);
        wait_end("load2");
        check("load2_done", 32'(bus.done),     32'd1);
        check("load2_hold", 32'(bus.cpu_hold), 32'd0);
        check("load2_left", 32'(exp_q.size()), 32'd0);

        // Empty image
        pulse_start();
        send_stream(empty_img, 1'b0);
        wait_end("empty");
        check("empty_done",  32'(bus.done),  32'd1);
        check("empty_error", 32'(bus.error), 32'd0);

        // Reset mid-word, then a clean load
        pulse_start();
        send_stream(partial, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_hold",  32'(bus.cpu_hold),   32'd0);
        check("midrst_ready", 32'(bus.byte_ready), 32'd0);
        check("midrst_data",  32'(bus.imem_data),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        push_two();
        send_stream(two_words, 1'b0);
        wait_end("after_rst");
        check("after_rst_done", 32'(bus.done),     32'd1);
        check("after_rst_left", 32'(exp_q.size()), 32'd0);

        // Restart mid-word, then a clean load
        pulse_start();
        send_stream(partial, 1'b0);
        pulse_start();
        check("midstart_ready", 32'(bus.byte_ready), 32'd1);
        check("midstart_hold",  32'(bus.cpu_hold),   32'd1);
        push_two();
        send_stream(two_words, 1'b0);
        wait_end("after_start");
        check("after_start_done", 32'(bus.done),     32'd1);
        check("after_start_left", 32'(exp_q.size()), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum: word is written, load still fails
        begin
            logic [7:0] bad[$];
            bad = '{8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h06};
            pulse_start();
            exp_q.push_back('{16'h0000, 16'h0005});
            send_stream(bad, 1'b0);
            wait_end("badsum");
            check("badsum_error", 32'(bus.error),    32'd1);
            check("badsum_done",  32'(bus.done),     32'd0);
            check("badsum_hold",  32'(bus.cpu_hold), 32'd1);
            check("badsum_left",  32'(exp_q.size()), 32'd0);
        end
`endif

        // Oversized image on a 16-word memory
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.byte_valid = 1'b1;
        bus4.bdata = 8'h00;
        check("big_ready", 32'(bus4.byte_ready), 32'd1);
        @(negedge clk);
        bus4.bdata = 8'h11;
        @(negedge clk);
        bus4.byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("big_error",  32'(bus4.error),      32'd1);
        check("big_done",   32'(bus4.done),       32'd0);
        check("big_hold",   32'(bus4.cpu_hold),   32'd1);
        check("big_ready2", 32'(bus4.byte_ready), 32'd0);
        check("big_writes", 32'(wr4),             32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
